pgm_wr_mslot: RTL and testbench
===============================

Name: pgm_wr_mslot

Overview:
Parametrised write side of the packet generator. It classifies packets arriving from the previous module. Packets whose head word carries the generate mark are stored as templates in one of SLOTS RAM slots; all other packets are forwarded to pgm_rd with their PHV. After each template commit the block raises start/finish flags to the read side, and the gap between them is set by cfg_gap.

Parameters:
DATA_W, 134, packet word width; [DATA_W-1:DATA_W-2] is the word type (01 head, 11 body, 10 tail).
PHV_W, 1024, PHV width.
RAM_W, 144, RAM word width; data is zero-extended to this width.
SLOTS, 4, number of template slots; power of 2, minimum 2.
DEPTH, 128, words per slot; power of 2.
SLOT_W, $clog2(SLOTS), slot index width.
OFS_W, $clog2(DEPTH), in-slot offset width.

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
in_wr_data  in  DATA_W  packet word
in_wr_data_wr  in  1  word strobe
in_wr_phv  in  PHV_W  PHV, valid with the head word
in_wr_phv_wr  in  1  PHV strobe
out_wr_alf  out  1  almost-full to upstream
out_wr_data  out  DATA_W  bypassed word to pgm_rd
out_wr_data_wr  out  1  bypass word strobe
out_wr_phv  out  PHV_W  bypassed PHV
out_wr_phv_wr  out  1  PHV strobe
in_wr_alf  in  1  almost-full from pgm_rd
wr2ram_wr_en  out  1  RAM write enable
wr2ram_addr  out  SLOT_W+OFS_W  RAM address, {slot, offset}
wr2ram_wdata  out  RAM_W  RAM write data
slot_vld  out  SLOTS  per-slot template-valid bit
slot_len  out  SLOTS*(OFS_W+1)  per-slot committed word count, flattened
pgm_bypass_flag  out  1  high while a bypass packet is in flight
pgm_sent_start  out  1  one-cycle pulse at template commit
pgm_start_slot  out  SLOT_W  committed slot index, valid with pgm_sent_start
pgm_sent_finish  out  1  one-cycle pulse when the gap expires
pgm_err  out  1  one-cycle pulse on overflow or protocol error
cfg_gap  in  32  gap cycles from start to finish
cfg_bypass_all  in  1  force bypass of every packet

Behaviour:
- Reset: every output is 0, state is IDLE, and slot_vld and slot_len are cleared. Reset has priority over every event, including mid-packet and mid-WAIT; a packet in flight is lost with no flag pulse.
- Word qualification: only words with in_wr_data_wr=1 are acted on. Idle cycles hold the state, and outputs with a _wr or _en suffix return to 0.
- Head classification: the head is "store" when bits [111:109]==3'b111 and cfg_bypass_all=0. The target slot is bits [108:108-SLOT_W+1]. Any other head is "bypass".
- out_wr_alf = in_wr_alf | (state==WAIT).
- States:
  - IDLE:
    - Bypass head: register word and PHV to the outputs, pulse _wr, set pgm_bypass_flag, go to BYPASS.
    - Store head: write it at {slot,0}, clear slot_vld[slot], set ofs=1, go to STORE.
    - A non-head word: pulse pgm_err, go to DISCARD.
  - BYPASS:
    - Forward 11 and 10 words with 1-cycle latency; out_wr_phv_wr pulses only with the head.
    - On a 10 word: forward it, clear pgm_bypass_flag, go to IDLE.
    - On a 01 word: pulse pgm_err, forward nothing, go to DISCARD.
  - STORE:
    - Write each 11/10 word at {slot,ofs}, then increment ofs.
    - On a 10 word with ofs<DEPTH: write it, set slot_len[slot]=ofs+1 and slot_vld[slot]=1, pulse pgm_sent_start with pgm_start_slot=slot, load gap_cnt=cfg_gap, go to WAIT.
    - On ofs==DEPTH with any word, or on a 01 word: no write, slot_vld[slot] stays 0, pulse pgm_err, go to DISCARD (or IDLE if that word was a 10).
  - WAIT:
    - Decrement gap_cnt each cycle.
    - When gap_cnt==0: pulse pgm_sent_finish, go to IDLE. cfg_gap=0 gives finish 1 cycle after start.
    - Incoming words are ignored (upstream honours out_wr_alf).
  - DISCARD: drop words until a 10 word, then go to IDLE on the next cycle. There are no RAM writes and no output strobes in this state.
- Width rules:
  - wr2ram_wdata = {(RAM_W-DATA_W)'b0, word}.
  - ofs is OFS_W+1 bits wide, so there is no wrap-around inside a slot.
  - gap_cnt is 32-bit unsigned.
- Simultaneous events: cfg_gap is sampled only at commit, and cfg_bypass_all only at the head word.

Decomposition:
- Shared package pgm_pkg: word-type constants (HEAD=2'b01, BODY=2'b11, TAIL=2'b10), the generate-mark field position and value (bits [111:109] == 3'b111), the slot-select field position, and the state enum (IDLE, BYPASS, STORE, WAIT, DISCARD).
- One sub-module, pgm_slot_tbl: holds slot_vld/slot_len and handles the invalidate-on-head and commit-on-tail updates.

Test Plan:
- Bypass path: 3-word packet with bits[111:109]=3'b010 → out words match input 1 cycle later; out_wr_phv_wr=1 only on the head; pgm_bypass_flag high 3 cycles; wr2ram_wr_en stays 0.
- Store and commit: 5-word store packet to slot 2 with cfg_gap=4 →
  - addresses {2,0}..{2,4} are written;
  - slot_len[2]=5 and slot_vld[2]=1;
  - pgm_sent_start pulses with pgm_start_slot=2;
  - pgm_sent_finish pulses 5 cycles after the start pulse;
  - out_wr_alf is high during WAIT.
- Overflow: DEPTH+1-word store packet to slot 1 → exactly DEPTH writes, pgm_err pulse, slot_vld[1]=0, next packet handled normally.
- Protocol error: a head word arriving mid-BYPASS → pgm_err pulse; the packet is dropped up to its tail; a following clean bypass packet passes.
- Reset mid-STORE: assert rst for 1 cycle during word 3 → all outputs 0, slot_vld=0, state is IDLE; a subsequent store to slot 0 succeeds.
- Override: cfg_bypass_all=1 with a store-marked head → the packet is bypassed and there are no RAM writes.

Source files
------------

// File: rtl/pgm_pkg.sv
// Shared definitions for the packet-generator write side.
// Holds the packet word-type codes, the generate-mark and slot-select field
// positions inside a head word, and the write-side state encoding.
package pgm_pkg;

    // Word type, carried in the top two bits of every packet word
    localparam logic [1:0] WT_HEAD = 2'b01;
    localparam logic [1:0] WT_BODY = 2'b11;
    localparam logic [1:0] WT_TAIL = 2'b10;

    // Generate mark: a head with [111:109] == 3'b111 is a template to store
    localparam int unsigned GEN_MARK_HI  = 111;
    localparam int unsigned GEN_MARK_LO  = 109;
    localparam logic [2:0]  GEN_MARK_VAL = 3'b111;

    // Target slot index starts here and extends SLOT_W bits downward
    localparam int unsigned SLOT_SEL_HI = 108;

    typedef enum logic [2:0] {
        IDLE,
        BYPASS,
        STORE,
        WAIT,
        DISCARD
    } pgm_state_t;

endpackage

// File: rtl/pgm_slot_tbl.sv
// Template slot table.
// Tracks, per slot, whether a complete template is present and how many
// words it holds. A slot is invalidated when a new template head targets it
// and becomes valid again only when that template commits on its tail.
//   clk, rst       : clock, synchronous active-high reset
//   inv_en/inv_slot: clear the valid bit of one slot
//   commit_*       : set valid and record word count for one slot
//   slot_vld       : per-slot valid bits
//   slot_len       : per-slot word counts, slot i at [i*LEN_W +: LEN_W]
module pgm_slot_tbl
    import pgm_pkg::*;
#(
    parameter int unsigned SLOTS  = 4,
    parameter int unsigned SLOT_W = $clog2(SLOTS),
    parameter int unsigned LEN_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inv_en,
    input  logic [SLOT_W-1:0]      inv_slot,
    input  logic                   commit_en,
    input  logic [SLOT_W-1:0]      commit_slot,
    input  logic [LEN_W-1:0]       commit_len,
    output logic [SLOTS-1:0]       slot_vld,
    output logic [SLOTS*LEN_W-1:0] slot_len
);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
            slot_len <= '0;
        end else begin
            if (inv_en) begin
                slot_vld[inv_slot] <= 1'b0;
            end
            if (commit_en) begin
                slot_vld[commit_slot]                  <= 1'b1;
                slot_len[commit_slot*LEN_W +: LEN_W]   <= commit_len;
            end
        end
    end

endmodule

// File: rtl/pgm_wr_mslot.sv
// Packet-generator write side with multiple template slots.
// Head words carrying the generate mark start a template that is written
// into RAM slot {slot, offset}; every other packet is forwarded to pgm_rd
// with one cycle of latency. A committed template raises pgm_sent_start,
// then pgm_sent_finish after cfg_gap+1 cycles, during which upstream is
// held off through out_wr_alf.
//   clk, rst                  : clock, synchronous active-high reset
//   in_wr_*                   : packet words and PHV from upstream
//   out_wr_alf                : almost-full to upstream
//   out_wr_*                  : bypassed words and PHV towards pgm_rd
//   in_wr_alf                 : almost-full from pgm_rd
//   wr2ram_*                  : template RAM write port
//   slot_vld, slot_len        : per-slot template status
//   pgm_bypass_flag           : high while bypass words are on out_wr_data
//   pgm_sent_start/_start_slot: commit pulse and slot
//   pgm_sent_finish           : gap expiry pulse
//   pgm_err                   : overflow / protocol error pulse
//   cfg_gap, cfg_bypass_all   : configuration
module pgm_wr_mslot
    import pgm_pkg::*;
#(
    parameter int unsigned DATA_W = 134,
    parameter int unsigned PHV_W  = 1024,
    parameter int unsigned RAM_W  = 144,
    parameter int unsigned SLOTS  = 4,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned SLOT_W = $clog2(SLOTS),
    parameter int unsigned OFS_W  = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            in_wr_data,
    input  logic                         in_wr_data_wr,
    input  logic [PHV_W-1:0]             in_wr_phv,
    input  logic                         in_wr_phv_wr,
    output logic                         out_wr_alf,
    output logic [DATA_W-1:0]            out_wr_data,
    output logic                         out_wr_data_wr,
    output logic [PHV_W-1:0]             out_wr_phv,
    output logic                         out_wr_phv_wr,
    input  logic                         in_wr_alf,
    output logic                         wr2ram_wr_en,
    output logic [SLOT_W+OFS_W-1:0]      wr2ram_addr,
    output logic [RAM_W-1:0]             wr2ram_wdata,
    output logic [SLOTS-1:0]             slot_vld,
    output logic [SLOTS*(OFS_W+1)-1:0]   slot_len,
    output logic                         pgm_bypass_flag,
    output logic                         pgm_sent_start,
    output logic [SLOT_W-1:0]            pgm_start_slot,
    output logic                         pgm_sent_finish,
    output logic                         pgm_err,
    input  logic [31:0]                  cfg_gap,
    input  logic                         cfg_bypass_all
);

    localparam int unsigned LEN_W  = OFS_W + 1;
    localparam int unsigned ADDR_W = SLOT_W + OFS_W;

    pgm_state_t state_q, state_d;

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [LEN_W-1:0]  ofs_q, ofs_d;
    logic [31:0]       gap_q, gap_d;

    logic [DATA_W-1:0] out_data_d;
    logic              out_data_wr_d;
    logic [PHV_W-1:0]  out_phv_d;
    logic              out_phv_wr_d;
    logic              ram_en_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [RAM_W-1:0]  ram_wdata_d;
    logic              bypass_flag_d;
    logic              start_d;
    logic [SLOT_W-1:0] start_slot_d;
    logic              finish_d;
    logic              err_d;

    logic              inv_en;
    logic              commit_en;
    logic [LEN_W-1:0]  commit_len;

    logic [1:0]        wtype;
    logic              is_head;
    logic              is_tail;
    logic              mark_hit;
    logic [SLOT_W-1:0] head_slot;
    logic              slot_full;

    // The PHV strobe carries no information beyond the head word itself
    logic unused_phv_wr;
    assign unused_phv_wr = in_wr_phv_wr;

    assign wtype     = in_wr_data[DATA_W-1 -: 2];
    assign is_head   = (wtype == WT_HEAD);
    assign is_tail   = (wtype == WT_TAIL);
    assign mark_hit  = (in_wr_data[GEN_MARK_HI:GEN_MARK_LO] == GEN_MARK_VAL);
    assign head_slot = in_wr_data[SLOT_SEL_HI -: SLOT_W];
    assign slot_full = (ofs_q == LEN_W'(DEPTH));

    assign out_wr_alf = in_wr_alf | (state_q == WAIT);
    assign commit_len = ofs_q + LEN_W'(1);

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        ofs_d         = ofs_q;
        gap_d         = gap_q;
        out_data_d    = out_wr_data;
        out_data_wr_d = 1'b0;
        out_phv_d     = out_wr_phv;
        out_phv_wr_d  = 1'b0;
        ram_en_d      = 1'b0;
        ram_addr_d    = wr2ram_addr;
        ram_wdata_d   = wr2ram_wdata;
        bypass_flag_d = 1'b0;
        start_d       = 1'b0;
        start_slot_d  = pgm_start_slot;
        finish_d      = 1'b0;
        err_d         = 1'b0;
        inv_en        = 1'b0;
        commit_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_wr_data_wr) begin
                    if (is_head && mark_hit && !cfg_bypass_all) begin
                        ram_en_d    = 1'b1;
                        ram_addr_d  = {head_slot, {OFS_W{1'b0}}};
                        ram_wdata_d = RAM_W'(in_wr_data);
                        slot_d      = head_slot;
                        ofs_d       = LEN_W'(1);
                        inv_en      = 1'b1;
                        state_d     = STORE;
                    end else if (is_head) begin
                        out_data_d    = in_wr_data;
                        out_data_wr_d = 1'b1;
                        out_phv_d     = in_wr_phv;
                        out_phv_wr_d  = 1'b1;
                        bypass_flag_d = 1'b1;
                        state_d       = BYPASS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end

            BYPASS: begin
                // The flag tracks the output side, so it stays up through
                // the cycle in which the forwarded tail is presented.
                bypass_flag_d = 1'b1;
                if (in_wr_data_wr) begin
                    if (is_head) begin
                        err_d         = 1'b1;
                        bypass_flag_d = 1'b0;
                        state_d       = DISCARD;
                    end else begin
                        out_data_d    = in_wr_data;
                        out_data_wr_d = 1'b1;
                        if (is_tail) begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            STORE: begin
                if (in_wr_data_wr) begin
                    if (slot_full || is_head) begin
                        err_d   = 1'b1;
                        state_d = is_tail ? IDLE : DISCARD;
                    end else begin
                        ram_en_d    = 1'b1;
                        ram_addr_d  = {slot_q, ofs_q[OFS_W-1:0]};
                        ram_wdata_d = RAM_W'(in_wr_data);
                        ofs_d       = ofs_q + LEN_W'(1);
                        if (is_tail) begin
                            commit_en    = 1'b1;
                            start_d      = 1'b1;
                            start_slot_d = slot_q;
                            gap_d        = cfg_gap;
                            state_d      = WAIT;
                        end
                    end
                end
            end

            WAIT: begin
                if (gap_q == '0) begin
                    finish_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end

            DISCARD: begin
                if (in_wr_data_wr && is_tail) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            slot_q          <= '0;
            ofs_q           <= '0;
            gap_q           <= '0;
            out_wr_data     <= '0;
            out_wr_data_wr  <= 1'b0;
            out_wr_phv      <= '0;
            out_wr_phv_wr   <= 1'b0;
            wr2ram_wr_en    <= 1'b0;
            wr2ram_addr     <= '0;
            wr2ram_wdata    <= '0;
            pgm_bypass_flag <= 1'b0;
            pgm_sent_start  <= 1'b0;
            pgm_start_slot  <= '0;
            pgm_sent_finish <= 1'b0;
            pgm_err         <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            ofs_q           <= ofs_d;
            gap_q           <= gap_d;
            out_wr_data     <= out_data_d;
            out_wr_data_wr  <= out_data_wr_d;
            out_wr_phv      <= out_phv_d;
            out_wr_phv_wr   <= out_phv_wr_d;
            wr2ram_wr_en    <= ram_en_d;
            wr2ram_addr     <= ram_addr_d;
            wr2ram_wdata    <= ram_wdata_d;
            pgm_bypass_flag <= bypass_flag_d;
            pgm_sent_start  <= start_d;
            pgm_start_slot  <= start_slot_d;
            pgm_sent_finish <= finish_d;
            pgm_err         <= err_d;
        end
    end

    pgm_slot_tbl #(
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W),
        .LEN_W  (LEN_W)
    ) u_slot_tbl (
        .clk         (clk),
        .rst         (rst),
        .inv_en      (inv_en),
        .inv_slot    (head_slot),
        .commit_en   (commit_en),
        .commit_slot (slot_q),
        .commit_len  (commit_len),
        .slot_vld    (slot_vld),
        .slot_len    (slot_len)
    );

endmodule

// File: tb/tb_pgm_wr_mslot.sv
module tb_pgm_wr_mslot;

    localparam int unsigned DATA_W = 134;
    localparam int unsigned PHV_W  = 1024;
    localparam int unsigned RAM_W  = 144;
    localparam int unsigned SLOTS  = 4;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned SLOT_W = 2;
    localparam int unsigned OFS_W  = 7;
    localparam int unsigned LEN_W  = 8;

    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b11;
    localparam logic [1:0] T = 2'b10;

    logic                       clk;
    logic                       rst;
    logic [DATA_W-1:0]          in_wr_data;
    logic                       in_wr_data_wr;
    logic [PHV_W-1:0]           in_wr_phv;
    logic                       in_wr_phv_wr;
    logic                       out_wr_alf;
    logic [DATA_W-1:0]          out_wr_data;
    logic                       out_wr_data_wr;
    logic [PHV_W-1:0]           out_wr_phv;
    logic                       out_wr_phv_wr;
    logic                       in_wr_alf;
    logic                       wr2ram_wr_en;
    logic [SLOT_W+OFS_W-1:0]    wr2ram_addr;
    logic [RAM_W-1:0]           wr2ram_wdata;
    logic [SLOTS-1:0]           slot_vld;
    logic [SLOTS*LEN_W-1:0]     slot_len;
    logic                       pgm_bypass_flag;
    logic                       pgm_sent_start;
    logic [SLOT_W-1:0]          pgm_start_slot;
    logic                       pgm_sent_finish;
    logic                       pgm_err;
    logic [31:0]                cfg_gap;
    logic                       cfg_bypass_all;

    pgm_wr_mslot #(
        .DATA_W (DATA_W),
        .PHV_W  (PHV_W),
        .RAM_W  (RAM_W),
        .SLOTS  (SLOTS),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_wr_data      (in_wr_data),
        .in_wr_data_wr   (in_wr_data_wr),
        .in_wr_phv       (in_wr_phv),
        .in_wr_phv_wr    (in_wr_phv_wr),
        .out_wr_alf      (out_wr_alf),
        .out_wr_data     (out_wr_data),
        .out_wr_data_wr  (out_wr_data_wr),
        .out_wr_phv      (out_wr_phv),
        .out_wr_phv_wr   (out_wr_phv_wr),
        .in_wr_alf       (in_wr_alf),
        .wr2ram_wr_en    (wr2ram_wr_en),
        .wr2ram_addr     (wr2ram_addr),
        .wr2ram_wdata    (wr2ram_wdata),
        .slot_vld        (slot_vld),
        .slot_len        (slot_len),
        .pgm_bypass_flag (pgm_bypass_flag),
        .pgm_sent_start  (pgm_sent_start),
        .pgm_start_slot  (pgm_start_slot),
        .pgm_sent_finish (pgm_sent_finish),
        .pgm_err         (pgm_err),
        .cfg_gap         (cfg_gap),
        .cfg_bypass_all  (cfg_bypass_all)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_wr, n_err, n_flag, n_dwr, n_pwr;
    logic [SLOT_W+OFS_W-1:0] addr_q[$];

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled there too,
    // so each step observes what the preceding rising edge registered.
    task automatic step();
        @(negedge clk);
        if (wr2ram_wr_en) begin
            n_wr++;
            addr_q.push_back(wr2ram_addr);
        end
        if (pgm_err)         n_err++;
        if (pgm_bypass_flag) n_flag++;
        if (out_wr_data_wr)  n_dwr++;
        if (out_wr_phv_wr)   n_pwr++;
    endtask

    task automatic clr();
        n_wr = 0; n_err = 0; n_flag = 0; n_dwr = 0; n_pwr = 0;
        addr_q.delete();
    endtask

    function automatic logic [DATA_W-1:0] mk(input logic [1:0] t, input logic [2:0] mark,
                                             input logic [1:0] slot, input logic [15:0] tag);
        logic [DATA_W-1:0] w;
        w = '0;
        w[133:132] = t;
        w[111:109] = mark;
        w[108:107] = slot;
        w[15:0]    = tag;
        return w;
    endfunction

    task automatic put(input logic [1:0] t, input logic [2:0] mark,
                       input logic [1:0] slot, input logic [15:0] tag);
        in_wr_data    = mk(t, mark, slot, tag);
        in_wr_data_wr = 1'b1;
        in_wr_phv_wr  = (t == H);
        step();
        in_wr_data_wr = 1'b0;
        in_wr_phv_wr  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_wr_data_wr = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int found;
        int alf_cnt;

        rst            = 1'b1;
        in_wr_data     = '0;
        in_wr_data_wr  = 1'b0;
        in_wr_phv      = {16{64'hA5A5_0000_1234_5678}};
        in_wr_phv_wr   = 1'b0;
        in_wr_alf      = 1'b0;
        cfg_gap        = 32'd0;
        cfg_bypass_all = 1'b0;
        clr();
        step();
        step();
        chk("rst_data_wr", 144'(out_wr_data_wr), 144'(0));
        chk("rst_ram_en",  144'(wr2ram_wr_en),   144'(0));
        chk("rst_vld",     144'(slot_vld),       144'(0));
        chk("rst_len",     144'(slot_len),       144'(0));
        chk("rst_alf",     144'(out_wr_alf),     144'(0));
        chk("rst_flag",    144'(pgm_bypass_flag), 144'(0));
        rst = 1'b0;
        idle(1);

        // Bypass path
        clr();
        put(H, 3'b010, 2'd0, 16'h0011);
        chk("byp_h_data", 144'(out_wr_data), 144'(mk(H, 3'b010, 2'd0, 16'h0011)));
        chk("byp_h_wr",   144'(out_wr_data_wr), 144'(1));
        chk("byp_h_pwr",  144'(out_wr_phv_wr), 144'(1));
        chk("byp_h_phv",  144'(out_wr_phv[63:0]), 144'(64'hA5A5_0000_1234_5678));
        put(B, 3'b010, 2'd0, 16'h0012);
        chk("byp_b_data", 144'(out_wr_data), 144'(mk(B, 3'b010, 2'd0, 16'h0012)));
        chk("byp_b_pwr",  144'(out_wr_phv_wr), 144'(0));
        put(T, 3'b010, 2'd0, 16'h0013);
        chk("byp_t_data", 144'(out_wr_data), 144'(mk(T, 3'b010, 2'd0, 16'h0013)));
        chk("byp_t_flag", 144'(pgm_bypass_flag), 144'(1));
        idle(2);
        chk("byp_idle_wr",  144'(out_wr_data_wr), 144'(0));
        chk("byp_flag_cyc", 144'(n_flag), 144'(3));
        chk("byp_pwr_cnt",  144'(n_pwr), 144'(1));
        chk("byp_no_ram",   144'(n_wr), 144'(0));

        // Store and commit to slot 2, gap 4
        clr();
        cfg_gap = 32'd4;
        put(H, 3'b111, 2'd2, 16'h0020);
        put(B, 3'b111, 2'd0, 16'h0021);
        put(B, 3'b000, 2'd0, 16'h0022);
        put(B, 3'b000, 2'd0, 16'h0023);
        put(T, 3'b000, 2'd0, 16'h0024);
        chk("st_wdata", 144'(wr2ram_wdata), 144'(mk(T, 3'b000, 2'd0, 16'h0024)));
        chk("st_start", 144'(pgm_sent_start), 144'(1));
        chk("st_sslot", 144'(pgm_start_slot), 144'(2));
        chk("st_vld2",  144'(slot_vld[2]), 144'(1));
        chk("st_len2",  144'(slot_len[2*LEN_W +: LEN_W]), 144'(5));
        chk("st_alf",   144'(out_wr_alf), 144'(1));
        chk("st_nwr",   144'(n_wr), 144'(5));
        for (int i = 0; i < 5; i++)
            chk("st_addr", 144'((i < addr_q.size()) ? addr_q[i] : 9'h1FF), 144'(256 + i));
        cfg_gap = 32'd77;
        found = 0;
        alf_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            if (pgm_sent_finish) begin
                found = k;
                break;
            end
            if (out_wr_alf) alf_cnt++;
        end
        chk("st_fin_delay", 144'(found), 144'(5));
        chk("st_alf_wait",  144'(alf_cnt), 144'(4));
        chk("st_alf_after", 144'(out_wr_alf), 144'(0));

        // Re-store slot 2 with gap 0: head invalidates, finish 1 cycle after start
        cfg_gap = 32'd0;
        put(H, 3'b111, 2'd2, 16'h0030);
        chk("g0_inv2", 144'(slot_vld[2]), 144'(0));
        put(T, 3'b000, 2'd0, 16'h0031);
        chk("g0_start", 144'(pgm_sent_start), 144'(1));
        chk("g0_len2",  144'(slot_len[2*LEN_W +: LEN_W]), 144'(2));
        idle(1);
        chk("g0_fin", 144'(pgm_sent_finish), 144'(1));

        // Overflow: DEPTH+1 words to slot 1
        clr();
        put(H, 3'b111, 2'd1, 16'h0100);
        for (int i = 1; i < DEPTH; i++) put(B, 3'b000, 2'd0, 16'(i));
        put(T, 3'b000, 2'd0, 16'h0FFF);
        idle(1);
        chk("ov_nwr",  144'(n_wr), 144'(DEPTH));
        chk("ov_err",  144'(n_err), 144'(1));
        chk("ov_vld1", 144'(slot_vld[1]), 144'(0));
        chk("ov_last", 144'((addr_q.size() > 0) ? addr_q[addr_q.size()-1] : 9'h0), 144'(255));
        put(H, 3'b111, 2'd3, 16'h0200);
        put(T, 3'b000, 2'd0, 16'h0201);
        chk("ov_next_vld3", 144'(slot_vld[3]), 144'(1));
        chk("ov_next_len3", 144'(slot_len[3*LEN_W +: LEN_W]), 144'(2));
        idle(2);

        // Protocol error: head arrives mid-bypass
        put(H, 3'b000, 2'd0, 16'h0040);
        put(B, 3'b000, 2'd0, 16'h0041);
        clr();
        put(H, 3'b000, 2'd0, 16'h0042);
        chk("pe_err",  144'(pgm_err), 144'(1));
        chk("pe_flag", 144'(pgm_bypass_flag), 144'(0));
        put(B, 3'b000, 2'd0, 16'h0043);
        put(T, 3'b000, 2'd0, 16'h0044);
        chk("pe_dropped", 144'(n_dwr), 144'(0));
        chk("pe_nerr",    144'(n_err), 144'(1));
        put(H, 3'b001, 2'd0, 16'h0050);
        put(T, 3'b001, 2'd0, 16'h0051);
        chk("pe_clean_data", 144'(out_wr_data), 144'(mk(T, 3'b001, 2'd0, 16'h0051)));
        chk("pe_clean_wr",   144'(out_wr_data_wr), 144'(1));
        idle(2);

        // Reset during word 3 of a store
        put(H, 3'b111, 2'd0, 16'h0060);
        put(B, 3'b000, 2'd0, 16'h0061);
        rst = 1'b1;
        put(B, 3'b000, 2'd0, 16'h0062);
        chk("rs_ram_en", 144'(wr2ram_wr_en), 144'(0));
        chk("rs_vld",    144'(slot_vld), 144'(0));
        chk("rs_data",   144'(out_wr_data), 144'(0));
        chk("rs_addr",   144'(wr2ram_addr), 144'(0));
        rst = 1'b0;
        idle(1);
        put(H, 3'b111, 2'd0, 16'h0070);
        put(B, 3'b000, 2'd0, 16'h0071);
        put(T, 3'b000, 2'd0, 16'h0072);
        chk("rs_start", 144'(pgm_sent_start), 144'(1));
        chk("rs_vld0",  144'(slot_vld), 144'(4'b0001));
        chk("rs_len0",  144'(slot_len[0 +: LEN_W]), 144'(3));
        idle(2);

        // Bypass override on a store-marked head
        clr();
        cfg_bypass_all = 1'b1;
        put(H, 3'b111, 2'd1, 16'h0080);
        chk("ovr_wr",   144'(out_wr_data_wr), 144'(1));
        chk("ovr_data", 144'(out_wr_data), 144'(mk(H, 3'b111, 2'd1, 16'h0080)));
        put(T, 3'b000, 2'd0, 16'h0081);
        cfg_bypass_all = 1'b0;
        idle(2);
        chk("ovr_no_ram", 144'(n_wr), 144'(0));
        chk("ovr_vld",    144'(slot_vld), 144'(4'b0001));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
